// File: rtl/pipelined_lane_shifter.sv
// Pipelined alignment shifter: one FP32 lane or two FP16 lanes, with per-lane sticky.
// Valid/ready handshake, optional inner registers, synchronous flush, fmt/tag passthrough.

package pipelined_lane_shifter_pkg;
    typedef enum logic [1:0] {
        FMT_FP32 = 2'b00,
        FMT_FP16 = 2'b01
    } fp_fmt_e;
endpackage

module pipelined_lane_shifter
    import pipelined_lane_shifter_pkg::*;
#(
    parameter logic [3:0] PIPE_MASK = 4'b0010,
    parameter int         TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  fp_fmt_e          in_fmt,
    input  logic [23:0]      in_x,
    input  logic [7:0]       in_s,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [25:0]      out_r,
    output logic             out_sticky_h,
    output logic             out_sticky_l,
    output fp_fmt_e          out_fmt,
    output logic [TAG_W-1:0] out_tag
);

    // In FP16 mode the hi lane lives in data[25:16] and the lo lane in data[9:0].
    typedef struct packed {
        logic             valid;
        fp_fmt_e          fmt;
        logic [TAG_W-1:0] tag;
        logic [7:0]       shamt;
        logic [25:0]      data;
        logic             stk_h;
        logic             stk_l;
    } beat_t;

    typedef struct packed {
        logic             valid;
        fp_fmt_e          fmt;
        logic [TAG_W-1:0] tag;
        logic [25:0]      data;
        logic             stk_h;
        logic             stk_l;
    } res_t;

    // One binary shift stage of 2**lg; anything not FP32 takes the dual-lane path.
    function automatic beat_t shift_stage(input beat_t b, input logic [2:0] lg);
        beat_t       r;
        logic [4:0]  k;
        logic [2:0]  hidx;
        logic [25:0] m32;
        logic [9:0]  m16;
        logic [9:0]  hi;
        logic [9:0]  lo;
        r    = b;
        k    = 5'd1 << lg;
        hidx = lg + 3'd4;
        m32  = (26'd1 << k) - 26'd1;
        m16  = (10'd1 << k) - 10'd1;
        hi   = b.data[25:16];
        lo   = b.data[9:0];
        if (b.fmt == FMT_FP32) begin
            if (b.shamt[lg]) begin
                r.stk_l = b.stk_l | (|(b.data & m32));
                r.data  = b.data >> k;
            end
        end else if (lg < 3'd4) begin
            if (b.shamt[hidx]) begin
                r.stk_h = b.stk_h | (|(hi & m16));
                hi      = hi >> k;
            end
            if (b.shamt[lg]) begin
                r.stk_l = b.stk_l | (|(lo & m16));
                lo      = lo >> k;
            end
            r.data = {hi, 6'b0, lo};
        end
        return r;
    endfunction

    beat_t beat_in;
    beat_t final_in;
    beat_t final_out;
    res_t  out_d;
    res_t  out_q;
    logic  stall;

    assign stall    = out_q.valid & ~out_ready;
    assign in_ready = ~stall;

    always_comb begin
        // NOTE: every always_comb target gets a full default first so no path can infer a latch.
        beat_in       = '0;
        beat_in.valid = in_valid;
        beat_in.fmt   = in_fmt;
        beat_in.tag   = in_tag;
        beat_in.shamt = in_s;
        if (in_fmt == FMT_FP32) begin
            beat_in.data = {in_x, 2'b00};
        end else begin
            beat_in.data = {in_x[23:16], 2'b00, 6'b0, in_x[7:0], 2'b00};
        end
    end

    // Stages 0..3 shift by 16/8/4/2; each is registered when its PIPE_MASK bit is set.
    for (genvar i = 0; i < 4; i++) begin : g_stage
        beat_t stage_in;
        beat_t stage_out;
        beat_t stage_link;

        if (i == 0) begin : g_first
            assign stage_in = beat_in;
        end else begin : g_next
            assign stage_in = g_stage[i-1].stage_link;
        end

        assign stage_out = shift_stage(stage_in, 3'(4 - i));

        if (PIPE_MASK[3-i]) begin : g_reg
            beat_t stage_d;
            beat_t stage_q;

            always_comb begin
                stage_d = stage_q;
                if (!stall) stage_d = stage_out;
                if (flush)  stage_d.valid = 1'b0;
            end

            // NOTE: data is reset along with valid so no X can ever reach out_r/out_tag.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    // NOTE: sequential state uses non-blocking assignment only.
                    stage_q <= '0;
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign stage_link = stage_q;
        end else begin : g_wire
            assign stage_link = stage_out;
        end
    end

    assign final_in  = g_stage[3].stage_link;
    assign final_out = shift_stage(final_in, 3'd0);

    always_comb begin
        out_d = out_q;
        if (!stall) begin
            out_d.valid = final_out.valid;
            out_d.fmt   = final_out.fmt;
            out_d.tag   = final_out.tag;
            out_d.data  = final_out.data;
            out_d.stk_h = final_out.stk_h;
            out_d.stk_l = final_out.stk_l;
        end
        if (flush) out_d.valid = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out_valid    = out_q.valid;
    assign out_r        = out_q.data;
    assign out_sticky_h = out_q.stk_h;
    assign out_sticky_l = out_q.stk_l;
    assign out_fmt      = out_q.fmt;
    assign out_tag      = out_q.tag;

endmodule

// File: tb/tb_pipelined_lane_shifter.sv
// Directed bench for pipelined_lane_shifter: datapath vectors, latency per PIPE_MASK,
// backpressure ordering, flush and asynchronous reset.

module tb_pipelined_lane_shifter;
    import pipelined_lane_shifter_pkg::*;

    typedef struct packed {
        fp_fmt_e     fmt;
        logic [23:0] x;
        logic [7:0]  s;
        logic [25:0] r;
        logic        h;
        logic        l;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    fp_fmt_e     in_fmt = FMT_FP32;
    logic [23:0] in_x = '0;
    logic [7:0]  in_s = '0;
    logic [3:0]  in_tag = '0;

    logic        in_ready, out_valid, out_sticky_h, out_sticky_l;
    logic [25:0] out_r;
    fp_fmt_e     out_fmt;
    logic [3:0]  out_tag;

    logic        in_ready_m0, out_valid_m0, out_sticky_h_m0, out_sticky_l_m0;
    logic [25:0] out_r_m0;
    fp_fmt_e     out_fmt_m0;
    logic [3:0]  out_tag_m0;

    logic        in_ready_mf, out_valid_mf, out_sticky_h_mf, out_sticky_l_mf;
    logic [25:0] out_r_mf;
    fp_fmt_e     out_fmt_mf;
    logic [3:0]  out_tag_mf;

    int   n_tests = 0;
    int   n_fail = 0;
    vec_t vecs [11];
    vec_t bp [4];

    always #5 clk = ~clk;

    pipelined_lane_shifter #(.PIPE_MASK(4'b0010), .TAG_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_x(in_x), .in_s(in_s), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
        .out_sticky_h(out_sticky_h), .out_sticky_l(out_sticky_l),
        .out_fmt(out_fmt), .out_tag(out_tag)
    );

    pipelined_lane_shifter #(.PIPE_MASK(4'b0000), .TAG_W(4)) u_dut_m0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_m0),
        .in_fmt(in_fmt), .in_x(in_x), .in_s(in_s), .in_tag(in_tag),
        .out_valid(out_valid_m0), .out_ready(out_ready), .out_r(out_r_m0),
        .out_sticky_h(out_sticky_h_m0), .out_sticky_l(out_sticky_l_m0),
        .out_fmt(out_fmt_m0), .out_tag(out_tag_m0)
    );

    pipelined_lane_shifter #(.PIPE_MASK(4'b1111), .TAG_W(4)) u_dut_mf (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_mf),
        .in_fmt(in_fmt), .in_x(in_x), .in_s(in_s), .in_tag(in_tag),
        .out_valid(out_valid_mf), .out_ready(out_ready), .out_r(out_r_mf),
        .out_sticky_h(out_sticky_h_mf), .out_sticky_l(out_sticky_l_mf),
        .out_fmt(out_fmt_mf), .out_tag(out_tag_mf)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic check_out(input string name, input vec_t v, input logic [3:0] tag);
        check({name, ".r"},   32'(out_r),        32'(v.r));
        check({name, ".sth"}, 32'(out_sticky_h), 32'(v.h));
        check({name, ".stl"}, 32'(out_sticky_l), 32'(v.l));
        check({name, ".fmt"}, 32'(out_fmt),      32'(v.fmt));
        check({name, ".tag"}, 32'(out_tag),      32'(tag));
    endtask

    // Called on a negedge; returns on the negedge after the beat was accepted.
    task automatic send(input vec_t v, input logic [3:0] tag);
        logic acc;
        int   waits;
        acc      = 1'b0;
        waits    = 0;
        in_valid = 1'b1;
        in_fmt   = v.fmt;
        in_x     = v.x;
        in_s     = v.s;
        in_tag   = tag;
        while (!acc && waits < 40) begin
            #4;
            acc = in_ready;
            @(posedge clk);
            if (!acc) begin
                @(negedge clk);
                waits++;
            end
        end
        check("send.accepted", 32'(acc), 32'd1);
        @(negedge clk);
    endtask

    task automatic run_beat(input int idx, input vec_t v);
        int    k;
        string name;
        name = $sformatf("vec%0d", idx);
        send(v, 4'(idx));
        in_valid = 1'b0;
        k = 1;
        while (!out_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        check({name, ".lat"}, 32'(k), 32'd2);
        check_out(name, v, 4'(idx));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat_m0, lat_m2, lat_mf;
        logic [25:0] r_m0, r_mf;
        int   got, hold, seen, ghost, seen_k;

        vecs = '{
            '{FMT_FP32, 24'h800001, 8'h03, 26'h0400000, 1'b0, 1'b1},
            '{FMT_FP16, 24'hFFA581, 8'h23, 26'h0FF0040, 1'b0, 1'b1},
            '{FMT_FP16, 24'hFF0081, 8'h23, 26'h0FF0040, 1'b0, 1'b1},
            '{FMT_FP32, 24'h000001, 8'hFF, 26'h0000000, 1'b0, 1'b1},
            '{FMT_FP16, 24'h015501, 8'hAA, 26'h0000000, 1'b1, 1'b1},
            '{FMT_FP32, 24'hABCDEF, 8'h00, 26'h2AF37BC, 1'b0, 1'b0},
            '{FMT_FP32, 24'hFFFFFF, 8'h1A, 26'h0000000, 1'b0, 1'b1},
            '{FMT_FP32, 24'h800000, 8'h19, 26'h0000001, 1'b0, 1'b0},
            '{FMT_FP16, 24'hFF00FF, 8'h90, 26'h00103FC, 1'b1, 1'b0},
            '{FMT_FP16, 24'h00FF00, 8'h55, 26'h0000000, 1'b0, 1'b0},
            '{FMT_FP16, 24'h80FF01, 8'h09, 26'h2000000, 1'b0, 1'b1}
        };
        bp = '{vecs[0], vecs[1], vecs[3], vecs[4]};

        // Reset state while rst_n is held low.
        repeat (2) @(negedge clk);
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.r",     32'(out_r),     32'd0);
        check("rst.stl",   32'(out_sticky_l), 32'd0);
        check("rst.sth",   32'(out_sticky_h), 32'd0);
        check("rst.tag",   32'(out_tag),   32'd0);
        check("rst.fmt",   32'(out_fmt),   32'(FMT_FP32));
        check("rst.ready", 32'(in_ready),  32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Latency for each PIPE_MASK instance from one shared beat.
        lat_m0 = 0; lat_m2 = 0; lat_mf = 0; r_m0 = '0; r_mf = '0;
        send(vecs[0], 4'd9);
        in_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) @(negedge clk);
            if (out_valid_m0 && lat_m0 == 0) begin lat_m0 = k; r_m0 = out_r_m0; end
            if (out_valid    && lat_m2 == 0) lat_m2 = k;
            if (out_valid_mf && lat_mf == 0) begin lat_mf = k; r_mf = out_r_mf; end
        end
        check("lat.mask0000", 32'(lat_m0), 32'd1);
        check("lat.mask0010", 32'(lat_m2), 32'd2);
        check("lat.mask1111", 32'(lat_mf), 32'd5);
        check("lat.mask0000.r", 32'(r_m0), 32'h0400000);
        check("lat.mask1111.r", 32'(r_mf), 32'h0400000);
        repeat (2) @(negedge clk);

        for (int i = 0; i < 11; i++) run_beat(i, vecs[i]);
        repeat (2) @(negedge clk);

        // Backpressure: 4 mixed-format beats, output held for 3 cycles once valid.
        got = 0; hold = 0; seen = 0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(bp[i], 4'(i));
                in_valid = 1'b0;
            end
            begin
                for (int it = 0; it < 40 && got < 4; it++) begin
                    @(negedge clk);
                    if (out_valid && seen == 0) begin
                        seen = 1;
                        out_ready = 1'b0;
                    end
                    #1;
                    if (seen == 1 && hold < 3) begin
                        check($sformatf("bp.hold%0d.ready", hold), 32'(in_ready), 32'd0);
                        check($sformatf("bp.hold%0d.valid", hold), 32'(out_valid), 32'd1);
                        check_out($sformatf("bp.hold%0d", hold), bp[0], 4'd0);
                        hold++;
                        if (hold == 3) out_ready = 1'b1;
                        #1;
                    end
                    if (out_valid && out_ready) begin
                        check_out($sformatf("bp.beat%0d", got), bp[got], 4'(got));
                        got++;
                    end
                end
                check("bp.count", 32'(got), 32'd4);
            end
        join
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Flush with two beats in flight and a third presented.
        out_ready = 1'b0;
        send(vecs[0], 4'd5);
        send(vecs[1], 4'd6);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_tag   = 4'd7;
        #1;
        check("flush.ready_in_cycle", 32'(in_ready), 32'd0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush.valid", 32'(out_valid), 32'd0);
        check("flush.ready_after", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        send(vecs[4], 4'd8);
        in_valid = 1'b0;
        ghost = 0; seen_k = 0;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) @(negedge clk);
            if (out_valid) begin
                if (out_tag == 4'd8 && seen_k == 0) begin
                    seen_k = k;
                    check_out("flush.next", vecs[4], 4'd8);
                end else begin
                    ghost++;
                end
            end
        end
        check("flush.next.lat", 32'(seen_k), 32'd2);
        check("flush.ghosts", 32'(ghost), 32'd0);
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-stream, between clock edges.
        out_ready = 1'b0;
        send(vecs[0], 4'hA);
        in_valid = 1'b0;
        for (int k = 0; k < 10 && !out_valid; k++) @(negedge clk);
        check("areset.pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset.valid", 32'(out_valid), 32'd0);
        check("areset.stl",   32'(out_sticky_l), 32'd0);
        check("areset.sth",   32'(out_sticky_h), 32'd0);
        check("areset.r",     32'(out_r), 32'd0);
        check("areset.tag",   32'(out_tag), 32'd0);
        check("areset.ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        run_beat(1, vecs[1]);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_lane_shifter.md
Name: pipelined_lane_shifter

Overview:
- Pipelined, back-pressurable successor to the shared FP32/dual-FP16 alignment shifter used in the FPALL add path.
- Right-shifts a 24-bit fraction payload, extended to 26 bits, in one of two modes: a single FP32 lane, or two independent 10-bit FP16 lanes. Produces per-lane sticky bits.
- Adds a configurable number of internal pipeline registers, a valid/ready handshake, per-beat format selection, tag passthrough and a synchronous flush.
- Sits between exponent-difference logic and the mantissa adder.

Parameters:
- PIPE_MASK, 4'b0010: bit3/2/1/0 inserts a register after the shift-by-16/8/4/2 stage respectively; the output register after the shift-by-1 stage is always present.
- TAG_W, 4: width of the opaque sideband tag carried alongside each beat.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous pipeline clear
- in_valid  input  1  input beat valid
- in_ready  output  1  block accepts a beat this cycle
- in_fmt  input  fp_fmt_e  FP32 or FP16; captured per beat
- in_x  input  24  FP32: fraction; FP16: hi lane in [23:16], lo lane in [7:0], [15:8] ignored
- in_s  input  8  FP32: shift amount in [4:0] ([7:5] ignored); FP16: hi shift in [7:4], lo shift in [3:0]
- in_tag  input  TAG_W  sideband, returned unchanged with the beat
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- out_r  output  26  shifted result
- out_sticky_h  output  1  hi-lane sticky; always 0 in FP32
- out_sticky_l  output  1  FP32: global sticky; FP16: lo-lane sticky
- out_fmt  output  fp_fmt_e  format of the beat on the output
- out_tag  output  TAG_W  tag of the beat on the output

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all stage valids 0, out_valid 0, out_r 0, both stickies 0, out_tag 0, out_fmt FP32. Reset mid-stream discards all in-flight beats.
- Latency: L = 1 + popcount(PIPE_MASK) cycles from acceptance (in_valid & in_ready) to out_valid, when there is no backpressure. Throughput is 1 beat per cycle.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - When stall is high, every pipeline register, including fmt, tag, partial sticky and valid, holds its value.
  - Bubbles are not collapsed.
  - out_r, out_sticky_*, out_fmt and out_tag stay stable while out_valid is high and out_ready is low.
- Beats exit in acceptance order. fmt travels with each beat, so back-to-back beats of different formats are legal with no dead cycle.
- FP32 datapath:
  - v = {in_x, 2'b00}; shift right by s = in_s[4:0] (0..31), zero-filled.
  - sticky_l = OR of all bits shifted out; shifts of 26..31 give out_r = 0 and sticky_l = |in_x.
  - sticky_h = 0.
- FP16 datapath:
  - hi = {in_x[23:16], 2'b00} and lo = {in_x[7:0], 2'b00}.
  - Each lane shifts right independently by its 4-bit amount (0..15), zero-filled; shifts of 10 or more empty the lane into its sticky.
  - Each sticky is the OR of the bits shifted out of that lane only; there is no cross-lane leakage.
  - out_r = {hi, 6'b0, lo}.
- Partial stickies are accumulated per stage and registered alongside the data at each PIPE_MASK boundary.
- flush:
  - On a clock edge with flush = 1, all stage valids and out_valid clear to 0; data registers may hold stale values.
  - flush overrides stall and any simultaneous acceptance: a beat presented in the flush cycle is dropped.
  - in_ready is unaffected by flush in that cycle.
- Unknown fmt encodings are treated as FP16.

Test Plan:
- FP32, in_x = 24'h800001, in_s = 8'h03 → after L cycles: out_r = 26'h0400000, sticky_l = 1, sticky_h = 0.
- FP16, in_x = 24'hFFA581, in_s = 8'h23 → out_r = 26'h0FF0040, sticky_h = 0, sticky_l = 1. A repeat with in_x[15:8] = 8'h00 gives identical output.
- FP32, in_x = 24'h000001, in_s = 8'hFF (effective shift 31) → out_r = 0, sticky_l = 1. FP16 with in_s = 8'hAA and in_x = 24'h01xx01 → out_r = 0, both stickies 1.
- Backpressure: accept 4 beats, tags 0..3, alternating FP32/FP16. Hold out_ready = 0 for 3 cycles once out_valid rises → in_ready = 0 and outputs stable throughout; then tags 0,1,2,3 emerge in order with correct per-format results.
- Flush: assert flush with 2 beats in flight plus in_valid high → next cycle out_valid = 0 and no flushed tag ever appears; a beat accepted the cycle after flush emerges L cycles later.
- Reset: drop rst_n asynchronously mid-stream → out_valid and the stickies go to 0 immediately, without a clock edge. Sweep PIPE_MASK over {0000, 0010, 1111} and check L = 1, 2 and 5 respectively.
